// File: rtl/wb_arb_pkg.sv
// Shared types, constants and helpers for the Wishbone round-robin arbiter.
// Holds the arbiter state enum, WB CTI codes and a $clog2 that never returns 0.
package wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first set req bit after 'last', wrapping.
// Ports: req (requests), last (previous owner) -> gnt_id (winner), any (some req).
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] gnt_id,
  output logic         any
);

  int idx;

  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      if (!any && req[idx]) begin
        any    = 1'b1;
        gnt_id = W'(idx);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone arbiter: N masters share one slave, whole CYC tenures.
// Ports: m_* packed master buses, s_* slave bus, grant_id/grant_vld status;
// timeout_flag only exists when WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter_rr
  import wb_arb_pkg::*;
#(
  parameter int N_MASTERS      = 4,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int IW             = clog2_min1(N_MASTERS),
  parameter int SW             = WB_DATA_WIDTH / 8
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [N_MASTERS-1:0]               m_cyc,
  input  logic [N_MASTERS-1:0]               m_stb,
  input  logic [N_MASTERS-1:0]               m_we,
  input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0] m_adr,
  input  logic [N_MASTERS*WB_DATA_WIDTH-1:0] m_dat_w,
  input  logic [N_MASTERS*SW-1:0]            m_sel,
  input  logic [N_MASTERS*3-1:0]             m_cti,
  input  logic [N_MASTERS*2-1:0]             m_bte,
  output logic [WB_DATA_WIDTH-1:0]           m_dat_r,
  output logic [N_MASTERS-1:0]               m_ack,
  output logic [N_MASTERS-1:0]               m_err,
  output logic                               s_cyc,
  output logic                               s_stb,
  output logic                               s_we,
  output logic [WB_ADDR_WIDTH-1:0]           s_adr,
  output logic [WB_DATA_WIDTH-1:0]           s_dat_w,
  output logic [SW-1:0]                      s_sel,
  output logic [2:0]                         s_cti,
  output logic [1:0]                         s_bte,
  input  logic [WB_DATA_WIDTH-1:0]           s_dat_r,
  input  logic                               s_ack,
  input  logic                               s_err,
  output logic [IW-1:0]                      grant_id,
  output logic                               grant_vld
`ifdef WB_ARB_TIMEOUT_EN
 ,output logic                               timeout_flag
`endif
);

  localparam int AW = WB_ADDR_WIDTH;
  localparam int DW = WB_DATA_WIDTH;

  if (N_MASTERS < 2 || N_MASTERS > 8 ||
      DW % 8 != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("wb_arbiter_rr: parameter out of range");
  end

  arb_state_t    state, state_nxt;
  logic [IW-1:0] last_grant, last_nxt, gid_nxt;
  logic [IW-1:0] pick_id;
  logic          pick_any;
  logic          own;
  logic          gate;
  logic          tmo_hit;
  int            gi;

  assign own       = (state == OWN);
  assign grant_vld = own;
  assign gi        = int'(grant_id);
  assign m_dat_r   = s_dat_r;

  wb_rr_pick #(
    .N (N_MASTERS),
    .W (IW)
  ) u_pick (
    .req    (m_cyc),
    .last   (last_grant),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= IW'(N_MASTERS - 1);
    end else begin
      state      <= state_nxt;
      grant_id   <= gid_nxt;
      last_grant <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gid_nxt   = grant_id;
    last_nxt  = last_grant;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_nxt = OWN;
          gid_nxt   = pick_id;
        end
      end
      OWN: begin
        if (!m_cyc[gi]) begin
          state_nxt = IDLE;
          last_nxt  = grant_id;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Payload is muxed unconditionally; it is don't-care while s_cyc=0.
  always_comb begin
    s_we    = m_we[gi];
    s_adr   = m_adr[gi*AW +: AW];
    s_dat_w = m_dat_w[gi*DW +: DW];
    s_sel   = m_sel[gi*SW +: SW];
    s_cti   = m_cti[gi*3 +: 3];
    s_bte   = m_bte[gi*2 +: 2];
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    m_ack   = '0;
    m_err   = '0;
    if (own && !gate) begin
      s_cyc     = m_cyc[gi];
      s_stb     = m_stb[gi] & m_cyc[gi];
      m_ack[gi] = s_ack;
      m_err[gi] = s_err;
    end
    if (tmo_hit) begin
      m_err[gi] = 1'b1;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt;
  logic          gated;

  // Once the watchdog fires the slave stays cut off until CYC drops.
  assign tmo_hit = own && !gated && (tmo_cnt == CW'(TIMEOUT_CYCLES));
  assign gate    = gated | tmo_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt      <= '0;
      gated        <= 1'b0;
      timeout_flag <= 1'b0;
    end else if (!own) begin
      tmo_cnt <= '0;
      gated   <= 1'b0;
    end else begin
      if (tmo_hit) begin
        gated        <= 1'b1;
        timeout_flag <= 1'b1;
      end
      if (!s_stb || s_ack || s_err) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign gate    = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed self-checking bench for wb_arbiter_rr (4 masters, 32-bit bus).
// Covers latency, round-robin order, bursts, ERR routing, async reset, timeout.
module tb_wb_arbiter_rr;
  import wb_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat_w;
  logic [N*4-1:0]  m_sel;
  logic [N*3-1:0]  m_cti;
  logic [N*2-1:0]  m_bte;
  logic [DW-1:0]   m_dat_r;
  logic [N-1:0]    m_ack, m_err;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_w;
  logic [3:0]      s_sel;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;
  logic [DW-1:0]   s_dat_r;
  logic            s_ack, s_err;
  logic [1:0]      grant_id;
  logic            grant_vld;
`ifdef WB_ARB_TIMEOUT_EN
  logic            timeout_flag;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_rr #(
    .N_MASTERS      (N),
    .WB_ADDR_WIDTH  (AW),
    .WB_DATA_WIDTH  (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .m_cyc     (m_cyc),
    .m_stb     (m_stb),
    .m_we      (m_we),
    .m_adr     (m_adr),
    .m_dat_w   (m_dat_w),
    .m_sel     (m_sel),
    .m_cti     (m_cti),
    .m_bte     (m_bte),
    .m_dat_r   (m_dat_r),
    .m_ack     (m_ack),
    .m_err     (m_err),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_we      (s_we),
    .s_adr     (s_adr),
    .s_dat_w   (s_dat_w),
    .s_sel     (s_sel),
    .s_cti     (s_cti),
    .s_bte     (s_bte),
    .s_dat_r   (s_dat_r),
    .s_ack     (s_ack),
    .s_err     (s_err),
    .grant_id  (grant_id),
    .grant_vld (grant_vld)
`ifdef WB_ARB_TIMEOUT_EN
   ,.timeout_flag (timeout_flag)
`endif
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in IDLE with master 'id' next in line; runs a 2-cycle transfer.
  task automatic serve(input int id, input bit rearm);
    logic [N-1:0] one;
    one = 4'b0001 << id;
    check("idle_vld", 64'(grant_vld), 64'd0);
    check("idle_cyc", 64'(s_cyc), 64'd0);
    tick();
    #1;
    check("gnt_vld", 64'(grant_vld), 64'd1);
    check("gnt_id", 64'(grant_id), 64'(id));
    check("gnt_cyc", 64'(s_cyc), 64'd1);
    check("gnt_stb", 64'(s_stb), 64'd1);
    check("gnt_adr", 64'(s_adr), 64'(32'h1000_0000 + id * 16));
    check("gnt_dat", 64'(s_dat_w), 64'(32'hA000_0000 + id));
    check("gnt_we", 64'(s_we), 64'(id % 2));
    check("wait_ack", 64'(m_ack), 64'd0);
    tick();
    s_ack = 1'b1;
    #1;
    check("ack_route", 64'(m_ack), 64'(one));
    tick();
    s_ack    = 1'b0;
    m_cyc[id] = 1'b0;
    #1;
    check("drop_cyc", 64'(s_cyc), 64'd0);
    check("drop_vld", 64'(grant_vld), 64'd1);
    tick();
    if (rearm) m_cyc[id] = 1'b1;
    #1;
  endtask

  initial begin
    rstn    = 1'b0;
    m_cyc   = '0;
    m_stb   = '1;
    m_we    = 4'b1010;
    m_cti   = '0;
    m_bte   = '0;
    m_sel   = '1;
    s_dat_r = '0;
    s_ack   = 1'b0;
    s_err   = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_adr[i*AW +: AW]   = 32'h1000_0000 + i * 16;
      m_dat_w[i*DW +: DW] = 32'hA000_0000 + i;
    end
    tick();
    #1;
    check("rst_vld", 64'(grant_vld), 64'd0);
    check("rst_id", 64'(grant_id), 64'd0);
    check("rst_cyc", 64'(s_cyc), 64'd0);
    check("rst_stb", 64'(s_stb), 64'd0);
    check("rst_ack", 64'(m_ack), 64'd0);
    check("rst_err", 64'(m_err), 64'd0);

    // One-cycle arbitration latency for a lone master 0.
    tick();
    rstn  = 1'b1;
    m_cyc = 4'b0001;
    #1;
    check("lat_cyc", 64'(s_cyc), 64'd0);
    serve(0, 1'b0);

    // Fresh reset, all masters continuously requesting: 0,1,2,3,0.
    rstn  = 1'b0;
    m_cyc = 4'b1111;
    #1;
    rstn = 1'b1;
    #1;
    serve(0, 1'b1);
    serve(1, 1'b1);
    serve(2, 1'b1);
    serve(3, 1'b1);
    serve(0, 1'b0);
    m_cyc = '0;
    #1;

    // Master 2 bursts while master 0 waits; no hand-over mid-burst.
    m_cyc = 4'b0100;
    m_cti[6 +: 3] = 3'b010;
    tick();
    #1;
    check("bst_id", 64'(grant_id), 64'd2);
    m_cyc[0] = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (b == 7) m_cti[6 +: 3] = CTI_EOB;
      s_ack = 1'b1;
      #1;
      check("bst_ack", 64'(m_ack), 64'b0100);
      check("bst_hold", 64'(grant_id), 64'd2);
      check("bst_cti", 64'(s_cti), (b == 7) ? 64'h7 : 64'h2);
      tick();
    end
    s_ack    = 1'b0;
    m_cyc[2] = 1'b0;
    #1;
    check("bst_end_cyc", 64'(s_cyc), 64'd0);
    check("bst_end_ack", 64'(m_ack), 64'd0);
    tick();
    #1;
    check("bst_gap", 64'(grant_vld), 64'd0);
    tick();
    #1;
    check("bst_next_id", 64'(grant_id), 64'd0);
    check("bst_next_vld", 64'(grant_vld), 64'd1);
    check("bst_next_cti", 64'(s_cti), 64'(CTI_CLASSIC));
    m_cyc[0] = 1'b0;
    tick();
    #1;

    // Responses in IDLE are dropped; ERR goes only to the owner.
    s_ack   = 1'b1;
    s_err   = 1'b1;
    s_dat_r = 32'hDEAD_BEEF;
    #1;
    check("idle_ack", 64'(m_ack), 64'd0);
    check("idle_err", 64'(m_err), 64'd0);
    check("dat_r", 64'(m_dat_r), 64'hDEAD_BEEF);
    s_ack = 1'b0;
    s_err = 1'b0;
    m_cyc = 4'b0010;
    tick();
    #1;
    check("err_id", 64'(grant_id), 64'd1);
    s_err = 1'b1;
    #1;
    check("err_route", 64'(m_err), 64'b0010);
    check("err_ack", 64'(m_ack), 64'd0);
    check("err_dat", 64'(m_dat_r), 64'hDEAD_BEEF);
    s_err = 1'b0;
    m_cyc = '0;
    tick();
    #1;

    // Asynchronous reset mid-tenure of master 3.
    m_cyc = 4'b1000;
    tick();
    #1;
    check("m3_id", 64'(grant_id), 64'd3);
    check("m3_cyc", 64'(s_cyc), 64'd1);
    rstn = 1'b0;
    #1;
    check("arst_cyc", 64'(s_cyc), 64'd0);
    check("arst_vld", 64'(grant_vld), 64'd0);
    check("arst_id", 64'(grant_id), 64'd0);
    m_cyc = 4'b1001;
    rstn  = 1'b1;
    tick();
    #1;
    check("arst_first", 64'(grant_id), 64'd0);
    check("arst_first_vld", 64'(grant_vld), 64'd1);

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never answers master 0; watchdog fires at count 16.
    for (int k = 0; k < 16; k++) begin
      check("tmo_wait_err", 64'(m_err), 64'd0);
      check("tmo_wait_stb", 64'(s_stb), 64'd1);
      tick();
      #1;
    end
    check("tmo_err", 64'(m_err), 64'b0001);
    check("tmo_cyc", 64'(s_cyc), 64'd0);
    tick();
    #1;
    check("tmo_pulse", 64'(m_err), 64'd0);
    check("tmo_gated", 64'(s_cyc), 64'd0);
    check("tmo_flag", 64'(timeout_flag), 64'd1);
    check("tmo_own", 64'(grant_vld), 64'd1);
    m_cyc[0] = 1'b0;
    tick();
    #1;
    check("tmo_idle", 64'(grant_vld), 64'd0);
    tick();
    #1;
    check("tmo_next", 64'(grant_id), 64'd3);
    check("tmo_next_cyc", 64'(s_cyc), 64'd1);
`endif

    m_cyc = '0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
